cordic_atan_seq: RTL

- Iterative CORDIC vectoring engine: accepts one signed (x, y) sample, returns its angle atan2(y, x) and its gain-scaled magnitude.
- Uses one add/shift rotation datapath (same sign rule, shift and angle-accumulate arithmetic as the pipelined atan stage) for ITER cycles, so one rotator serves each conversion.
- Sits between the baseband sample source and the phase/magnitude consumers.
- Used where area matters more than throughput.

---
 rtl/cordic_atan_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cordic_atan_seq.sv
// Iterative CORDIC vectoring engine: one shared add/shift rotator computes
// atan2(y, x) and the gain-scaled magnitude of a captured sample over ITER cycles.
module cordic_atan_seq #(
  parameter int ITER = 12
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_x,
  input  logic [31:0] rx_y,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_mag,
  output logic [11:0] tx_ang,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

  state_t      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [11:0] z_q, z_d;
  logic [31:0] mag_q, mag_d;
  logic [11:0] ang_q, ang_d;

  logic [31:0] x_sh, y_sh, x_rot, y_rot;
  logic [11:0] z_rot;
  logic        rot_neg;

  // atan(2^-i) in units of 360/4096 degrees
  function automatic logic [11:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 12'd512;
      4'd1:    atan_lut = 12'd302;
      4'd2:    atan_lut = 12'd160;
      4'd3:    atan_lut = 12'd81;
      4'd4:    atan_lut = 12'd41;
      4'd5:    atan_lut = 12'd20;
      4'd6:    atan_lut = 12'd10;
      4'd7:    atan_lut = 12'd5;
      4'd8:    atan_lut = 12'd3;
      4'd9:    atan_lut = 12'd1;
      4'd10:   atan_lut = 12'd1;
      default: atan_lut = 12'd0;
    endcase
  endfunction

  // Single rotation step; both updates read the old x/y registers.
  always_comb begin
    x_sh    = $signed(x_q) >>> i_q;
    y_sh    = $signed(y_q) >>> i_q;
    rot_neg = x_q[31] ^ y_q[31];
    if (rot_neg) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_lut(i_q);
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_lut(i_q);
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          // Left half-plane samples are mirrored through the origin first.
          if (rx_x[31]) begin
            x_d = 32'd0 - rx_x;
            y_d = 32'd0 - rx_y;
            z_d = 12'h800;
          end else begin
            x_d = rx_x;
            y_d = rx_y;
            z_d = 12'h000;
          end
          i_d     = 4'd0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + 4'd1;
        if (i_q == LAST_IDX) begin
          mag_d   = x_rot;
          ang_d   = z_rot;
          i_d     = 4'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 4'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      z_q     <= 12'd0;
      mag_q   <= 32'd0;
      ang_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign rx_ready = (state_q == S_IDLE);
  assign tx_valid = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign tx_mag   = mag_q;
  assign tx_ang   = ang_q;

endmodule
